// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : snn_pkg
// Brief    : Shared image geometry and loader state encoding for the SNN feeder.
// Revision : 1.0
// ============================================================================
package snn_pkg;

  localparam int IMG_PIXELS  = 784;
  localparam int IMG_BYTES   = 98;
  localparam int PIX_ADDR_W  = 10;
  localparam int BYTE_ADDR_W = 7;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/snn_img_buf.sv
`default_nettype none
// ============================================================================
// Module   : snn_img_buf
// Brief    : 98x8 image store with per-bit write mask and 1-bit registered read.
// Revision : 1.0
// ============================================================================
module snn_img_buf
  import snn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [BYTE_ADDR_W-1:0] waddr,
  input  logic [7:0]             wdata,
  input  logic [7:0]             wmask,
  input  logic [PIX_ADDR_W-1:0]  raddr,
  output logic                   q
);

  logic [7:0]             r_mem [IMG_BYTES];
  logic [BYTE_ADDR_W-1:0] w_rword;
  logic [2:0]             w_rbit;
  logic                   w_rin;

  assign w_rword = raddr[PIX_ADDR_W-1:3];
  assign w_rbit  = raddr[2:0];
  assign w_rin   = (raddr < PIX_ADDR_W'(IMG_PIXELS));

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= (r_mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= w_rin ? r_mem[w_rword][w_rbit] : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : snn_image_loader
// Brief    : Streams a 28x28 binary image into a buffer, kicks the SNN core,
//            serves its pixel reads and hands back the classified digit.
// Config   : SNN_LOADER_THRESH_EN - 784 grayscale bytes binarized by THRESHOLD
//            instead of the default 98 packed bytes (LSB first).
// Revision : 1.0
// ============================================================================
module snn_image_loader
  import snn_pkg::*;
#(
  parameter logic [7:0] THRESHOLD = 8'd127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  start,
  input  logic [PIX_ADDR_W-1:0] addr_input_unit,
  output logic                  q_input,
  input  logic [3:0]            digit,
  input  logic                  done,
  output logic [3:0]            res_digit,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

`ifdef SNN_LOADER_THRESH_EN
  localparam int c_cnt_w = PIX_ADDR_W;
  localparam int c_total = IMG_PIXELS;
`else
  localparam int c_cnt_w = BYTE_ADDR_W;
  localparam int c_total = IMG_BYTES;
  logic [7:0] w_unused_threshold;
  assign w_unused_threshold = THRESHOLD;
`endif
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_total - 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(c_total);

  loader_state_t          r_state;
  logic [c_cnt_w-1:0]     r_wcount;
  logic                   w_accept;
  logic                   w_last_accept;
  logic                   w_full_next;
  logic                   w_res_free;
  logic [BYTE_ADDR_W-1:0] w_waddr;
  logic [7:0]             w_wdata;
  logic [7:0]             w_wmask;

  assign w_accept      = in_valid && in_ready;
  assign w_last_accept = w_accept && (r_wcount == c_last);
  assign w_full_next   = (r_wcount == c_full) || w_last_accept;
  // The slot is free if nothing is pending or the pending result leaves this cycle.
  assign w_res_free    = !res_valid || res_ready;

`ifdef SNN_LOADER_THRESH_EN
  assign w_waddr = r_wcount[PIX_ADDR_W-1:3];
  assign w_wdata = {8{in_data > THRESHOLD}};
  assign w_wmask = 8'b1 << r_wcount[2:0];
`else
  assign w_waddr = r_wcount;
  assign w_wdata = in_data;
  assign w_wmask = 8'hFF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_wcount  <= '0;
      in_ready  <= 1'b1;
      start     <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_digit <= 4'd0;
    end else begin
      start <= 1'b0;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            r_wcount <= r_wcount + c_cnt_w'(1);
          end
          if (w_last_accept) begin
            in_ready <= 1'b0;
          end
          if (w_full_next && w_res_free) begin
            r_state <= START;
            start   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        START: begin
          r_state <= RUN;
        end
        RUN: begin
          // A capture here overrides a same-cycle consumption above.
          if (done) begin
            res_digit <= digit;
            res_valid <= 1'b1;
            r_wcount  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= LOAD;
          end
        end
        default: begin
          r_state <= LOAD;
        end
      endcase
    end
  end

  snn_img_buf u_img_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_accept),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .wmask (w_wmask),
    .raddr (addr_input_unit),
    .q     (q_input)
  );

endmodule
`default_nettype wire

// File: tb/tb_snn_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_image_loader
// Brief    : Scoreboard bench for snn_image_loader (pixel reads, start, results).
// Revision : 1.0
// ============================================================================
module tb_snn_image_loader;
  import snn_pkg::*;

`ifdef SNN_LOADER_THRESH_EN
  localparam int NB = IMG_PIXELS;
`else
  localparam int NB = IMG_BYTES;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       start;
  logic [9:0] addr_input_unit = 10'd0;
  logic       q_input;
  logic [3:0] digit = 4'd0;
  logic       done = 1'b0;
  logic [3:0] res_digit;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       busy;

  snn_image_loader #(.THRESHOLD(8'd127)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .start           (start),
    .addr_input_unit (addr_input_unit),
    .q_input         (q_input),
    .digit           (digit),
    .done            (done),
    .res_digit       (res_digit),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int a;
    bit e;
  } rd_t;

  int         checks = 0;
  int         errors = 0;
  bit         img_m [IMG_PIXELS];
  rd_t        rd_q [$];
  int         start_q [$];
  logic [3:0] res_q [$];
  bit         rd_en = 1'b0;
  bit         rd_prev = 1'b0;
  int         n_acc = 0;
  int         n_start = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
  always @(negedge clk) begin
    rd_t r;
    if (rst_n) begin
      if (in_valid && in_ready) n_acc++;
      if (rd_prev) begin
        if (rd_q.size() == 0) chk("rd_queue_underflow", 1, 0);
        else begin
          r = rd_q.pop_front();
          chk($sformatf("pix_read@%0d", r.a), int'(q_input), int'(r.e));
        end
      end
      if (start) begin
        n_start++;
        if (start_q.size() == 0) chk("unexpected_start_cycle", cyc, -1);
        else chk("start_cycle", cyc, start_q.pop_front());
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) chk("unexpected_result", int'(res_digit), -1);
        else chk("res_digit_handshake", int'(res_digit), int'(res_q.pop_front()));
      end
    end
    rd_prev = rd_en;
  end

  function automatic logic [7:0] enc(input int k);
    logic [7:0] b;
`ifdef SNN_LOADER_THRESH_EN
    b = img_m[k] ? 8'(128 + ((k >> 1) % 128)) : 8'(127 - ((k >> 1) % 128));
`else
    for (int j = 0; j < 8; j++) b[j] = img_m[8*k + j];
`endif
    return b;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < IMG_PIXELS; i++) img_m[i] = v[i % 8];
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IMG_PIXELS; i++) img_m[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic send_image(input int nbytes, input bit toggle, input bit expect_start);
    int k = 0;
    int guard = 0;
    while (k < nbytes) begin
      @(posedge clk); #2;
      in_data  = enc(k);
      in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (k == NB - 1 && expect_start) start_q.push_back(cyc + 1);
        k++;
      end
      guard++;
      if (guard > 8*NB + 100) begin
        chk("load_timeout_bytes", k, nbytes);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic rd(input int a, input bit e);
    @(posedge clk); #2;
    addr_input_unit = 10'(a);
    rd_en = 1'b1;
    rd_q.push_back('{a, e});
  endtask

  task automatic rd_end();
    @(posedge clk); #2;
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_all();
    for (int i = 0; i < IMG_PIXELS; i++) rd(i, img_m[i]);
    rd(784, 1'b0);
    rd(1023, 1'b0);
    rd_end();
  endtask

  task automatic pulse_done(input logic [3:0] d);
    @(posedge clk); #2;
    done  = 1'b1;
    digit = d;
    res_q.push_back(d);
    @(posedge clk); #2;
    done  = 1'b0;
    digit = 4'd0;
    @(negedge clk);
    chk("res_valid_after_done", int'(res_valid), 1);
    chk("res_digit_after_done", int'(res_digit), int'(d));
    chk("in_ready_after_done", int'(in_ready), 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic pulse_res_ready(input bit expect_start);
    @(posedge clk); #2;
    res_ready = 1'b1;
    if (expect_start) start_q.push_back(cyc + 1);
    @(posedge clk); #2;
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_q_input"}, int'(q_input), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_digit"}, int'(res_digit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs(tag);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int cnt;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outs("por");
    rst_n = 1'b1;

    // Image 1: constant 0xA5 stream, back to back.
    fill_const(8'hA5);
`ifdef SNN_LOADER_THRESH_EN
    img_m[0] = 1'b0;
    img_m[1] = 1'b1;
`endif
    send_image(NB, 1'b0, 1'b1);
    chk("busy_in_run", int'(busy), 1);
    rd(0, img_m[0]);
    rd(1, img_m[1]);
    rd(2, img_m[2]);
    rd(7, img_m[7]);
    rd(800, 1'b0);
    rd_end();
    chk("accepts_image1", n_acc, NB);
    chk("starts_image1", n_start, 1);

    // Result held while the consumer stalls.
    pulse_done(4'd7);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid && res_digit == 4'd7) cnt++;
    end
    chk("res_held_cycles", cnt, 20);

    // Image 2 loads while the result is still pending: start waits for the handshake.
    fill_rand();
    send_image(NB, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("no_start_while_pending", n_start, 1);
    chk("busy_while_pending", int'(busy), 0);
    chk("in_ready_when_complete", int'(in_ready), 0);
    pulse_res_ready(1'b1);
    repeat (3) @(negedge clk);
    chk("starts_after_handshake", n_start, 2);
    rd_all();
    pulse_done(4'd3);
    pulse_res_ready(1'b0);

    // Image 3: throttled stream, then extra in_valid while complete / running.
    fill_rand();
    acc0 = n_acc;
    send_image(NB, 1'b1, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (6) @(posedge clk);
    #2;
    in_valid = 1'b0;
    chk("accepts_throttled", n_acc - acc0, NB);
    rd_all();
    @(posedge clk); #2;
    res_ready = 1'b1;
    pulse_done(4'd9);
    @(posedge clk); #2;
    res_ready = 1'b0;

    // Reset mid-load, then a clean load.
    fill_rand();
    send_image(40, 1'b0, 1'b0);
    do_reset("rst_midload");
    fill_rand();
    acc0 = n_acc;
    send_image(NB, 1'b0, 1'b1);
    chk("accepts_after_rst", n_acc - acc0, NB);
    for (int i = 0; i < 16; i++) rd(i * 49, img_m[i * 49]);
    rd_end();

    // Reset mid-run, then another full load to finish with a result.
    do_reset("rst_midrun");
    fill_const(8'h3C);
    send_image(NB, 1'b0, 1'b1);
    rd(2, img_m[2]);
    rd(783, img_m[783]);
    rd_end();
    pulse_done(4'd5);
    pulse_res_ready(1'b0);
    repeat (4) @(negedge clk);
    chk("starts_total", n_start, 5);
    chk("start_q_left", start_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
